// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, select codes, decode classes.
// MC_JAL_EN (when defined) enables jal/jr; the encodings themselves do not change.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ext_0    = 2'd0;
  localparam logic [1:0] ext_sign = 2'd1;
  localparam logic [1:0] ext_lui  = 2'd2;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_REG = 2'd3;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;

  // one-hot instruction class bit positions
  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_ORI  = 2;
  localparam int C_LUI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_JR   = 9;
  localparam int C_NOP  = 10;
  localparam int NCLS   = 11;

  typedef logic [NCLS-1:0] cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, control/select/write-enables out.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic [1:0] ext_mod;
  logic [2:0] alu_op;
  logic       alu_srcb;
  logic       mem_we;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] reg_src;
  logic       instr_done;

  modport master (
    input  opcode, funct, alu_zero,
    output pc_we, pc_sel, ir_we, ext_mod, alu_op, alu_srcb,
           mem_we, reg_we, reg_dst, reg_src, instr_done
  );

  modport slave (
    output opcode, funct, alu_zero,
    input  pc_we, pc_sel, ir_we, ext_mod, alu_op, alu_srcb,
           mem_we, reg_we, reg_dst, reg_src, instr_done
  );
endinterface

// File: rtl/mc_decode.sv
// {opcode,funct} -> one-hot instruction class; exactly one bit is always set.
// MC_JAL_EN defined: jal/jr get their own classes, otherwise they fall into C_NOP.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls[C_ADDU] = 1'b1;
          FN_SUBU: cls[C_SUBU] = 1'b1;
`ifdef MC_JAL_EN
          FN_JR:   cls[C_JR]   = 1'b1;
`endif
          // includes sll/all-zero IR, which deliberately run as nop
          default: cls[C_NOP]  = 1'b1;
        endcase
      end
      OP_J:    cls[C_J]   = 1'b1;
`ifdef MC_JAL_EN
      OP_JAL:  cls[C_JAL] = 1'b1;
`endif
      OP_BEQ:  cls[C_BEQ] = 1'b1;
      OP_ORI:  cls[C_ORI] = 1'b1;
      OP_LUI:  cls[C_LUI] = 1'b1;
      OP_LW:   cls[C_LW]  = 1'b1;
      OP_SW:   cls[C_SW]  = 1'b1;
      default: cls[C_NOP] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with combinational control outputs.
// MC_JAL_EN enables jal/jr (handled in mc_decode; this file needs no guard of its own).
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  cls_t   cls;
  state_t state;

  logic       pc_we_c, ir_we_c, mem_we_c, reg_we_c, done_c, srcb_c;
  logic [1:0] pc_sel_c, ext_c, dst_c, src_c;
  logic [2:0] alu_c;

  mc_decode u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else begin
      unique case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (cls[C_JAL])                            state <= S_WB;
          else if (cls[C_J] | cls[C_JR] | cls[C_NOP]) state <= S_FETCH;
          else                                       state <= S_EXEC;
        end
        S_EXEC: begin
          if (cls[C_LW] | cls[C_SW]) state <= S_MEM;
          else if (cls[C_BEQ])       state <= S_FETCH;
          else                       state <= S_WB;
        end
        S_MEM:    state <= cls[C_LW] ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_we_c  = 1'b0;
    pc_sel_c = PC_SEQ;
    ir_we_c  = 1'b0;
    ext_c    = ext_0;
    alu_c    = ALU_ADD;
    srcb_c   = 1'b0;
    mem_we_c = 1'b0;
    reg_we_c = 1'b0;
    dst_c    = DST_RD;
    src_c    = SRC_ALU;
    done_c   = 1'b0;
    unique case (state)
      S_FETCH: begin
        ir_we_c = 1'b1;
        pc_we_c = 1'b1;
      end
      S_DECODE: begin
        if (cls[C_J] | cls[C_JAL]) begin
          pc_we_c  = 1'b1;
          pc_sel_c = PC_JMP;
          done_c   = cls[C_J];
        end else if (cls[C_JR]) begin
          pc_we_c  = 1'b1;
          pc_sel_c = PC_REG;
          done_c   = 1'b1;
        end else if (cls[C_NOP]) begin
          done_c   = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls[C_SUBU] | cls[C_BEQ]) alu_c = ALU_SUB;
        if (cls[C_ORI]) begin
          srcb_c = 1'b1;
          alu_c  = ALU_OR;
        end
        if (cls[C_LUI]) begin
          ext_c  = ext_lui;
          srcb_c = 1'b1;
          alu_c  = ALU_PASSB;
        end
        if (cls[C_LW] | cls[C_SW]) begin
          ext_c  = ext_sign;
          srcb_c = 1'b1;
        end
        // branch decision uses the flag of the compare computed this same cycle
        if (cls[C_BEQ]) begin
          pc_we_c  = bus.alu_zero;
          pc_sel_c = PC_BR;
          done_c   = 1'b1;
        end
      end
      S_MEM: begin
        if (cls[C_SW]) begin
          mem_we_c = 1'b1;
          done_c   = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        done_c   = 1'b1;
        if (cls[C_JAL])                     dst_c = DST_RA;
        else if (!(cls[C_ADDU] | cls[C_SUBU])) dst_c = DST_RT;
        if (cls[C_LW])       src_c = SRC_MEM;
        else if (cls[C_JAL]) src_c = SRC_PC4;
      end
      default: ;
    endcase
  end

  // reset suppresses every architectural write, so an abandoned instruction leaves no trace
  assign bus.pc_we      = pc_we_c  & ~reset;
  assign bus.ir_we      = ir_we_c  & ~reset;
  assign bus.mem_we     = mem_we_c & ~reset;
  assign bus.reg_we     = reg_we_c & ~reset;
  assign bus.instr_done = done_c   & ~reset;
  assign bus.pc_sel     = pc_sel_c;
  assign bus.ext_mod    = ext_c;
  assign bus.alu_op     = alu_c;
  assign bus.alu_srcb   = srcb_c;
  assign bus.reg_dst    = dst_c;
  assign bus.reg_src    = src_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle scripts queued by the driver, checked at negedge.
// Build with or without MC_JAL_EN; the jal/jr expectations follow the same macro.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ir_we;
    logic [1:0] ext_mod;
    logic [2:0] alu_op;
    logic       alu_srcb;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       instr_done;
  } out_t;

  typedef struct {
    out_t v;
    out_t m;
    int   kind;
    int   k;
  } chk_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_RST = 11;

  logic clk = 1'b0;
  logic reset;
  mc_ctrl_if bus ();
  chk_t q[$];
  int total = 0;
  int bad = 0;
  out_t full_m, we_m;

  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  // Reference: what each instruction does in its k-th cycle, straight from the ISA-level timing table.
  function automatic void model(input int kind, input int k, input logic z,
                                output out_t e, output bit last);
    e = '0;
    last = 1'b0;
    if (k == 0) begin
      e.ir_we = 1'b1;
      e.pc_we = 1'b1;
      return;
    end
    case (kind)
      K_ADDU, K_SUBU: begin
        if (k == 2) e.alu_op = (kind == K_SUBU) ? ALU_SUB : ALU_ADD;
        if (k == 3) begin e.reg_we = 1; e.reg_dst = DST_RD; e.reg_src = SRC_ALU; e.instr_done = 1; last = 1; end
      end
      K_ORI: begin
        if (k == 2) begin e.ext_mod = ext_0; e.alu_srcb = 1; e.alu_op = ALU_OR; end
        if (k == 3) begin e.reg_we = 1; e.reg_dst = DST_RT; e.instr_done = 1; last = 1; end
      end
      K_LUI: begin
        if (k == 2) begin e.ext_mod = ext_lui; e.alu_srcb = 1; e.alu_op = ALU_PASSB; end
        if (k == 3) begin e.reg_we = 1; e.reg_dst = DST_RT; e.instr_done = 1; last = 1; end
      end
      K_LW: begin
        if (k == 2) begin e.ext_mod = ext_sign; e.alu_srcb = 1; e.alu_op = ALU_ADD; end
        if (k == 4) begin e.reg_we = 1; e.reg_dst = DST_RT; e.reg_src = SRC_MEM; e.instr_done = 1; last = 1; end
      end
      K_SW: begin
        if (k == 2) begin e.ext_mod = ext_sign; e.alu_srcb = 1; e.alu_op = ALU_ADD; end
        if (k == 3) begin e.mem_we = 1; e.instr_done = 1; last = 1; end
      end
      K_BEQ: begin
        if (k == 2) begin e.alu_op = ALU_SUB; e.pc_we = z; e.pc_sel = PC_BR; e.instr_done = 1; last = 1; end
      end
      K_J: begin
        e.pc_we = 1; e.pc_sel = PC_JMP; e.instr_done = 1; last = 1;
      end
      K_JAL: begin
        if (!JAL_EN) begin e.instr_done = 1; last = 1; end
        else if (k == 1) begin e.pc_we = 1; e.pc_sel = PC_JMP; end
        else begin e.reg_we = 1; e.reg_dst = DST_RA; e.reg_src = SRC_PC4; e.instr_done = 1; last = 1; end
      end
      K_JR: begin
        if (JAL_EN) begin e.pc_we = 1; e.pc_sel = PC_REG; end
        e.instr_done = 1; last = 1;
      end
      default: begin e.instr_done = 1; last = 1; end
    endcase
  endfunction

  function automatic void pick_enc(input int kind, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (kind)
      K_ADDU: begin op = OP_RTYPE; fn = FN_ADDU; end
      K_SUBU: begin op = OP_RTYPE; fn = FN_SUBU; end
      K_ORI:  op = OP_ORI;
      K_LUI:  op = OP_LUI;
      K_LW:   op = OP_LW;
      K_SW:   op = OP_SW;
      K_BEQ:  op = OP_BEQ;
      K_J:    op = OP_J;
      K_JAL:  op = OP_JAL;
      K_JR:   begin op = OP_RTYPE; fn = FN_JR; end
      default: begin
        case ($urandom_range(0, 4))
          0: op = 6'h3f;
          1: begin op = 6'h00; fn = 6'h00; end
          2: begin op = 6'h00; fn = 6'h20; end
          3: op = 6'h08;
          default: op = 6'h01;
        endcase
      end
    endcase
  endfunction

  // zf: -1 random alu_zero each cycle; abort_at: stop after that many cycles (0 = run to end)
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input int zf, input int abort_at);
    out_t e;
    bit last;
    logic z;
    int k;
    k = 0;
    last = 1'b0;
    while (!last) begin
      @(posedge clk); #1;
      reset = 1'b0;
      z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      if (k == 0) begin
        // IR is being loaded this cycle; controller must not care what the stale fields say
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end else begin
        bus.opcode = op;
        bus.funct  = fn;
      end
      bus.alu_zero = z;
      model(kind, k, z, e, last);
      q.push_back('{v: e, m: full_m, kind: kind, k: k});
      k++;
      if (abort_at != 0 && k == abort_at) last = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      bus.opcode   = 6'($urandom);
      bus.funct    = 6'($urandom);
      bus.alu_zero = 1'($urandom_range(0, 1));
      q.push_back('{v: '0, m: we_m, kind: K_RST, k: i});
    end
  endtask

  task automatic run_rand(input int kind, input int abort_at);
    logic [5:0] op, fn;
    pick_enc(kind, op, fn);
    run_instr(kind, op, fn, -1, abort_at);
  endtask

  initial begin : monitor
    chk_t c;
    out_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        c = q.pop_front();
        act = {bus.pc_we, bus.pc_sel, bus.ir_we, bus.ext_mod, bus.alu_op, bus.alu_srcb,
               bus.mem_we, bus.reg_we, bus.reg_dst, bus.reg_src, bus.instr_done};
        total++;
        if ((act & c.m) !== (c.v & c.m)) begin
          bad++;
          $display("FAIL ctl kind=%0d cyc=%0d got=%b want=%b mask=%b @%0t",
                   c.kind, c.k, act, c.v, c.m, $time);
        end
      end
    end
  end

  initial begin : driver
    int kind, ab;
    full_m = '1;
    we_m = '0;
    we_m.pc_we = 1'b1; we_m.ir_we = 1'b1; we_m.mem_we = 1'b1;
    we_m.reg_we = 1'b1; we_m.instr_done = 1'b1;
    reset = 1'b1;
    bus.opcode = '0;
    bus.funct = '0;
    bus.alu_zero = 1'b0;

    do_reset(3);
    run_instr(K_ORI, OP_ORI, 6'h01, -1, 0);         // imm 16'h8001
    run_instr(K_LW,  OP_LW,  6'h10, -1, 0);
    run_instr(K_LUI, OP_LUI, 6'h3c, -1, 0);
    run_instr(K_BEQ, OP_BEQ, 6'h05, 1, 0);
    run_instr(K_BEQ, OP_BEQ, 6'h05, 0, 0);
    run_instr(K_JAL, OP_JAL, 6'h22, -1, 0);
    run_instr(K_JR,  OP_RTYPE, FN_JR, -1, 0);
    run_instr(K_NOP, 6'h3f, 6'h00, -1, 0);
    run_instr(K_NOP, 6'h00, 6'h00, -1, 0);          // all-zero IR / sll
    run_instr(K_LW,  OP_LW,  6'h00, -1, 3);         // reach MEM, then reset over it
    do_reset(3);
    run_instr(K_SW,  OP_SW,  6'h04, -1, 3);         // store abandoned in MEM
    do_reset(3);
    run_instr(K_ADDU, OP_RTYPE, FN_ADDU, -1, 0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(K_ADDU, K_NOP);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0;
      run_rand(kind, ab);
      if (ab != 0) do_reset($urandom_range(1, 3));
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the non-pipelined CPU variant. It sequences instruction fetch, decode, execute, memory and write-back over the shared datapath: PC, IR, register file, immediate extender, ALU and data memory. Each cycle it drives the extender mode, ALU operation, mux selects and all architectural write enables. It sits beside the datapath top and takes only the IR opcode/funct fields and the ALU zero flag as inputs.

## Interface
Parameters: none. Encodings come from the shared define file.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result == 0
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target {PC[31:28],IR[25:0],2'b00}, 3 GPR[rs]
- ir_we  out  1  IR write enable
- ext_mod  out  2  extender mode: `ext_0` / `ext_sign` / `ext_lui`
- alu_op  out  3  ALU op: ADD, SUB, OR, PASSB
- alu_srcb  out  1  0 GPR[rt], 1 extender output
- mem_we  out  1  data memory write enable
- reg_we  out  1  GPR write enable
- reg_dst  out  2  0 rd, 1 rt, 2 $31
- reg_src  out  2  0 ALU result register, 1 memory data register, 2 PC+4
- instr_done  out  1  one-cycle pulse in an instruction's final cycle

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. State register has 3 bits.
- FETCH: ir_we=1, pc_we=1, pc_sel=0. Next state is DECODE.
- DECODE: classify {opcode,funct}.
  - j: pc_we=1, pc_sel=2, instr_done, next FETCH.
  - jal/jr: see Configuration.
  - All other supported instructions: next EXEC.
  - Unsupported: instr_done, next FETCH, no write enable asserted (executes as nop).
- EXEC:
  - addu/subu: alu_srcb=0, alu_op ADD/SUB, next WB.
  - ori: ext_mod=`ext_0`, alu_srcb=1, OR, next WB.
  - lui: ext_mod=`ext_lui`, alu_srcb=1, PASSB, next WB.
  - lw/sw: ext_mod=`ext_sign`, alu_srcb=1, ADD, next MEM.
  - beq: alu_srcb=0, SUB, pc_we=alu_zero, pc_sel=1, instr_done, next FETCH.
- MEM:
  - sw: mem_we=1, instr_done, next FETCH.
  - lw: next WB.
- WB: reg_we=1, instr_done, next FETCH.
  - R-type: reg_dst=0, reg_src=0.
  - ori/lui: reg_dst=1, reg_src=0.
  - lw: reg_dst=1, reg_src=1.
- Outputs are combinational from the current state plus opcode/funct. Any output not listed for a state is 0 (ext_mod defaults to `ext_0`, alu_op to ADD).
- sll with funct 0 and an all-zero IR decode as unsupported, so they act as nop.

## Timing
- Reset: state←FETCH at the next clock edge. While reset is high, every *_we output and instr_done is forced to 0, regardless of state.
- Reset asserted mid-instruction abandons it. No partial write occurs in the reset cycle. The first post-reset cycle is FETCH.
- Cycles per instruction:
  - j, jr, unsupported: 2
  - beq, jal: 3
  - addu, subu, ori, lui, sw: 4
  - lw: 5
- beq samples alu_zero in EXEC, the same cycle the comparison is computed.
- At most one of pc_we, mem_we, reg_we is asserted per cycle, except FETCH, where pc_we and ir_we are both asserted.
- instr_done is high exactly once per instruction.

## Configuration
- MC_JAL_EN defined:
  - jal: DECODE does pc_we=1, pc_sel=2, next WB. WB does reg_we=1, reg_dst=2, reg_src=2. PC+4 comes from the datapath's latched old-PC+4 register.
  - jr (opcode 0, funct 6'h08): DECODE does pc_we=1, pc_sel=3, instr_done, next FETCH.
- MC_JAL_EN undefined: jal and jr decode as unsupported (2-cycle nop). reg_dst=2 and reg_src=2 are never driven.

## Structure
- Shared define file holds:
  - state encodings
  - opcode/funct constants
  - `ext_*` modes
  - ALU op codes
  - pc_sel/reg_dst/reg_src codes
- One sub-module, mc_decode: combinational {opcode,funct} → instruction-class one-hot. mc_ctrl instantiates it and holds the FSM and output logic.

## Test plan
- Reset held 3 cycles mid-lw (in MEM) → no mem_we/reg_we pulse; state FETCH on the first cycle after release; ir_we=1 that cycle.
- ori with imm 16'h8001 → EXEC shows ext_mod=`ext_0`, alu_op OR, alu_srcb=1; WB shows reg_we=1, reg_dst=1; instr_done only in WB; 4 cycles total.
- lw then lui back-to-back → lw takes 5 cycles with ext_mod=`ext_sign` in EXEC and reg_src=1 in WB; lui takes 4 cycles with ext_mod=`ext_lui`, alu_op PASSB.
- beq with alu_zero=1, then beq with alu_zero=0 → pc_we=1/pc_sel=1 in EXEC for the first; pc_we=0 for the second; both take 3 cycles.
- jal with MC_JAL_EN defined → DECODE pc_sel=2; WB reg_dst=2, reg_src=2; 3 cycles. Same build rerun without the macro → 2 cycles, no reg_we.
- Opcode 6'h3F → DECODE instr_done, back to FETCH, no write enables over 2 cycles.
